// File: rtl/bin_to_bcd_seq_if.sv
// Handshake bundle for the sequential binary-to-BCD converter.
// The master requests conversions; the slave reports busy/done and the result.
interface bin_to_bcd_seq_if #(
  parameter int BIN_WIDTH = 8,
  parameter int DIGITS    = 3
);
  logic                  start;
  logic [BIN_WIDTH-1:0]  bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;

  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  bcd_out
  );

  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output bcd_out
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one binary bit per cycle,
// then a one-cycle done pulse with the packed BCD result held until the next.
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH = 8,
  parameter int DIGITS    = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  bin_to_bcd_seq_if.slave bus
);

  localparam int CW = $clog2(BIN_WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e                state_q;
  logic [BIN_WIDTH-1:0]  sh_q;
  logic [BW-1:0]         scr_q;
  logic [BW-1:0]         bcd_q;
  logic [CW-1:0]         cnt_q;
  logic                  busy_q;
  logic                  done_q;

  logic [BW-1:0]         adj;
  logic [BW-1:0]         scr_d;
  logic                  unused_msb;

  always_comb begin
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
  end

  // Top bit cannot be set for a legal DIGITS/BIN_WIDTH pairing.
  assign scr_d      = {adj[BW-2:0], sh_q[BIN_WIDTH-1]};
  assign unused_msb = adj[BW-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            sh_q    <= bus.bin_in;
            scr_q   <= '0;
            cnt_q   <= CW'(BIN_WIDTH);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          scr_q <= scr_d;
          sh_q  <= {sh_q[BIN_WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            bcd_q   <= scr_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 Parameter: BIN_WIDTH, default 8, width of the unsigned binary operand.
REQ-002 Parameter: DIGITS, default 3, number of BCD output digits; legal only if 10^DIGITS > 2^BIN_WIDTH - 1.
REQ-003 The block SHALL use a single clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request to convert bin_in; sampled on rising clk.
REQ-007 bin_in  input  BIN_WIDTH  unsigned binary operand; sampled only on the accepting edge.
REQ-008 busy  output  1  conversion in progress; start is ignored while high.
REQ-009 done  output  1  single-cycle pulse; bcd_out is valid from this cycle.
REQ-010 bcd_out  output  4*DIGITS  packed BCD result, digit 0 (ones) in bits [3:0], ascending.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-012 IDLE, start=1: the block SHALL latch bin_in into a shift register, clear the BCD scratch register, load the bit counter with BIN_WIDTH, and enter SHIFT.
REQ-013 IDLE, start=0: the block SHALL hold all registers and outputs.
REQ-014 SHIFT, each cycle: every scratch digit >= 5 SHALL first get +3 (4-bit, no carry out of the digit), then {scratch, shift register} SHALL shift left one bit, binary MSB entering scratch bit 0; counter decrements by 1.
REQ-015 SHIFT: when the counter reaches 0 after the decrement, the block SHALL copy scratch into bcd_out and enter DONE.
REQ-016 DONE: done=1 for exactly that one cycle, then unconditional return to IDLE.
REQ-017 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.
REQ-018 Latency: for start accepted at edge N, done SHALL be high in the cycle following edge N+BIN_WIDTH (9 edges after acceptance for BIN_WIDTH=8, counting the accept edge).
REQ-019 bcd_out SHALL change only on entry to DONE and SHALL hold its value until the next conversion completes.
REQ-020 start asserted while busy=1, including the DONE cycle, SHALL be ignored, with no queuing.
REQ-021 Back-to-back: start=1 in the first IDLE cycle after done SHALL be accepted, giving a minimum period of BIN_WIDTH+2 cycles.
REQ-022 Every bcd_out digit SHALL always be in the range 0-9.
REQ-023 bin_in changes after the accepting edge SHALL NOT affect the in-flight result.

Reset
REQ-024 rst_n=0 SHALL asynchronously force: state IDLE, busy=0, done=0, bcd_out=0, and clear the scratch, shift and counter registers.
REQ-025 Reset asserted mid-conversion SHALL abort it with no done pulse; bcd_out SHALL read 0 after reset.
REQ-026 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-027 bin_in=0, start pulse -> done after 9 edges, bcd_out=12'h000.
REQ-028 bin_in=255 -> bcd_out=12'h255; bin_in=99 -> 12'h099; bin_in=100 -> 12'h100; bin_in=9 -> 12'h009.
REQ-029 Exhaustive sweep 0..255, back-to-back starts -> each bcd_out equals the decimal value, one done per start, period 10 cycles.
REQ-030 Convert 200, then pulse start with bin_in=17 at cycle 4 of busy -> ignored; bcd_out=12'h200; a single done.
REQ-031 Convert 123, assert rst_n=0 at cycle 5 -> busy, done and bcd_out=0 immediately; no done; a following convert of 45 -> 12'h045.
REQ-032 Change bin_in every cycle during a conversion of 150 -> bcd_out=12'h150.
